// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: tick/value inputs and multiplexed display outputs.
// The parameters must match the seg_scan_mux instance that uses this interface.
interface seg_scan_mux_if #(
    parameter int CH_N   = 8,
    parameter int VAL_W  = 8,
    parameter int DIGITS = 3
);
    localparam int CI_W = (CH_N > 1) ? $clog2(CH_N) : 1;

    logic                    scan_tick;
    logic                    rotate_tick;
    logic                    hold;
    logic [CH_N*VAL_W-1:0]   vals;
    logic [DIGITS-1:0]       digit;
    logic [7:0]              seg_data;
    logic [CI_W-1:0]         ch_idx;
    logic                    busy;
    logic                    ovf;

    modport master (
        output scan_tick, rotate_tick, hold, vals,
        input  digit, seg_data, ch_idx, busy, ovf
    );

    modport slave (
        input  scan_tick, rotate_tick, hold, vals,
        output digit, seg_data, ch_idx, busy, ovf
    );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: channel rotator, sequential binary-to-BCD and 7-segment scan.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits above position 0.
module seg_scan_mux #(
    parameter int CH_N   = 8,
    parameter int VAL_W  = 8,
    parameter int DIGITS = 3
) (
    input logic           clk,
    input logic           resetn,
    seg_scan_mux_if.slave io
);
    localparam int CI_W = (CH_N > 1) ? $clog2(CH_N) : 1;
    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(VAL_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CI_W-1:0]   ch_q, ch_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic [VAL_W-1:0]  bin_q, bin_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovfw_q, ovfw_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     disp_q, disp_d;
    logic              ovf_q, ovf_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic [7:0]        seg_q, seg_d;

    logic [BW-1:0]     bcd_adj;
    logic [DIGITS-1:0] dig_rot;
    logic [3:0]        nib;
    logic              pos0;
    logic [7:0]        base;
    logic              take;

    function automatic logic [7:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    dec7 = 8'hFC;
            4'd1:    dec7 = 8'h60;
            4'd2:    dec7 = 8'hDA;
            4'd3:    dec7 = 8'hF2;
            4'd4:    dec7 = 8'h66;
            4'd5:    dec7 = 8'hB6;
            4'd6:    dec7 = 8'hBE;
            4'd7:    dec7 = 8'hE0;
            4'd8:    dec7 = 8'hFE;
            4'd9:    dec7 = 8'hF6;
            default: dec7 = 8'h00;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    assign take = io.rotate_tick && !io.hold;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovfw_d  = ovfw_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        // A tick arriving mid-conversion is remembered once.
        if (state_q != IDLE && take)
            pend_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (take || pend_q) begin
                    ch_d    = (ch_q == CI_W'(CH_N - 1)) ? '0 : ch_q + 1'b1;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bin_d   = io.vals[int'(ch_q)*VAL_W +: VAL_W];
                bcd_d   = '0;
                ovfw_d  = 1'b0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d  = {bcd_adj[BW-2:0], bin_q[VAL_W-1]};
                bin_d  = bin_q << 1;
                ovfw_d = ovfw_q | bcd_adj[BW-1];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(VAL_W - 1))
                    state_d = DONE;
            end
            DONE: begin
                disp_d  = bcd_q;
                ovf_d   = ovfw_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dig_d   = dig_q;
        seg_d   = seg_q;
        dig_rot = (dig_q << 1) | (dig_q >> (DIGITS - 1));
        nib     = '0;
        pos0    = 1'b0;
        for (int p = 0; p < DIGITS; p++) begin
            if (dig_rot[p]) begin
                nib  = disp_q[4*p +: 4];
                pos0 = (p == 0);
            end
        end
        base = dec7(nib);
`ifdef LEAD_ZERO_BLANK_EN
        for (int p = 1; p < DIGITS; p++) begin
            if (dig_rot[p] && ((disp_q >> (4*p)) == '0))
                base = 8'h00;
        end
`endif
        if (ovf_q)
            base = 8'h02;
        if (io.scan_tick) begin
            dig_d = dig_rot;
            seg_d = base | {7'b0, io.hold & pos0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOAD;
            ch_q    <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovfw_q  <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            dig_q   <= DIGITS'(1);
            seg_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovfw_q  <= ovfw_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
        end
    end

    assign io.digit    = dig_q;
    assign io.seg_data = seg_q;
    assign io.ch_idx   = ch_q;
    assign io.busy     = busy_q;
    assign io.ovf      = ovf_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: vector table, corner sequences and random values checked
// against a decimal-arithmetic display model, for 3-digit and 2-digit builds.
module tb_seg_scan_mux;
    localparam logic [7:0] SEG_TAB [10] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
        8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6
    };

    typedef struct {
        int          d;
        int          v;
        logic [23:0] segs;
        logic        o;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg_scan_mux_if #(.CH_N(8), .VAL_W(8), .DIGITS(3)) io1 ();
    seg_scan_mux_if #(.CH_N(4), .VAL_W(8), .DIGITS(2)) io2 ();

    seg_scan_mux #(.CH_N(8), .VAL_W(8), .DIGITS(3)) u1 (
        .clk(clk), .resetn(rstn), .io(io1)
    );
    seg_scan_mux #(.CH_N(4), .VAL_W(8), .DIGITS(2)) u2 (
        .clk(clk), .resetn(rstn), .io(io2)
    );

    int npass = 0;
    int ntot  = 0;
    int val1 [8];
    int val2 [4];
    int ch1 = 0, ch2 = 0, pos1 = 0, pos2 = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r *= 10;
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int nd,
                                           input int p, input bit hd);
        logic [7:0] r;
        int pw;
        pw = pow10(p);
        if (v >= pow10(nd)) r = 8'h02;
        else begin
            r = SEG_TAB[(v / pw) % 10];
`ifdef LEAD_ZERO_BLANK_EN
            if (p > 0 && v < pw) r = 8'h00;
`endif
        end
        if (hd && p == 0) r[0] = 1'b1;
        return r;
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 1) ? io1.busy : io2.busy;
    endfunction

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        do begin
            lat++;
            step();
        end while (busy_of(d) && lat < 40);
    endtask

    task automatic rotate(input int d, output int lat);
        if (d == 1) io1.rotate_tick = 1'b1;
        else io2.rotate_tick = 1'b1;
        step();
        io1.rotate_tick = 1'b0;
        io2.rotate_tick = 1'b0;
        if (d == 1) begin
            ch1 = (ch1 + 1) % 8;
            check("ch_idx1", io1.ch_idx, ch1);
        end else begin
            ch2 = (ch2 + 1) % 4;
            check("ch_idx2", io2.ch_idx, ch2);
        end
        check($sformatf("busy_on%0d", d), busy_of(d), 1);
        wait_done(d, lat);
    endtask

    task automatic conv(input int d, input int v);
        int lat, nc;
        if (d == 1) begin
            nc = (ch1 + 1) % 8;
            io1.vals[nc*8 +: 8] = 8'(v);
            val1[nc] = v;
        end else begin
            nc = (ch2 + 1) % 4;
            io2.vals[nc*8 +: 8] = 8'(v);
            val2[nc] = v;
        end
        rotate(d, lat);
        check($sformatf("latency%0d", d), lat, 10);
    endtask

    task automatic scan1(input int d, output int p, output logic [7:0] s);
        if (d == 1) io1.scan_tick = 1'b1;
        else io2.scan_tick = 1'b1;
        step();
        io1.scan_tick = 1'b0;
        io2.scan_tick = 1'b0;
        if (d == 1) begin
            pos1 = (pos1 + 1) % 3;
            p = pos1;
            check("digit1", io1.digit, 1 << p);
            s = io1.seg_data;
        end else begin
            pos2 = (pos2 + 1) % 2;
            p = pos2;
            check("digit2", io2.digit, 1 << p);
            s = io2.seg_data;
        end
    endtask

    task automatic scan_model(input int d, input bit hd);
        int nd, v, p;
        logic [7:0] s;
        nd = (d == 1) ? 3 : 2;
        v  = (d == 1) ? val1[ch1] : val2[ch2];
        if (d == 1) io1.hold = hd;
        else io2.hold = hd;
        check($sformatf("ovf%0d v=%0d", d, v),
              (d == 1) ? io1.ovf : io2.ovf, v >= pow10(nd));
        for (int i = 0; i < nd; i++) begin
            scan1(d, p, s);
            check($sformatf("seg%0d v=%0d p=%0d", d, v, p), s,
                  exp_seg(v, nd, p, hd));
        end
    endtask

    initial begin
        vec_t tab [10];
        int lat, c0, nd, p, d, v;
        logic [7:0] s;
        logic [23:0] t;
        bit hd;

        tab[0] = '{1, 255, 24'hDA_B6_B6, 1'b0};
        tab[1] = '{1, 100, 24'h60_FC_FC, 1'b0};
        tab[2] = '{1, 209, 24'hDA_FC_F6, 1'b0};
        tab[3] = '{1, 147, 24'h60_66_E0, 1'b0};
        tab[4] = '{1, 250, 24'hDA_B6_FC, 1'b0};
        tab[5] = '{1, 128, 24'h60_DA_FE, 1'b0};
        tab[6] = '{2, 200, 24'h00_02_02, 1'b1};
        tab[7] = '{2, 99,  24'h00_F6_F6, 1'b0};
        tab[8] = '{2, 37,  24'h00_F2_E0, 1'b0};
        tab[9] = '{2, 100, 24'h00_02_02, 1'b1};

        io1.scan_tick = 0; io1.rotate_tick = 0; io1.hold = 0;
        io2.scan_tick = 0; io2.rotate_tick = 0; io2.hold = 0;
        for (int k = 0; k < 8; k++) begin
            val1[k] = 1 << k;
            io1.vals[k*8 +: 8] = 8'(val1[k]);
        end
        for (int k = 0; k < 4; k++) begin
            val2[k] = 10 * k + 5;
            io2.vals[k*8 +: 8] = 8'(val2[k]);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_digit", io1.digit, 1);
        check("rst_seg", io1.seg_data, 0);
        check("rst_busy", io1.busy, 1);
        check("rst_ch", io1.ch_idx, 0);
        check("rst_ovf", io1.ovf, 0);
        rstn = 1'b1;
        wait_done(1, lat);
        check("first_latency", lat, 10);
        check("first_busy2", io2.busy, 0);
        scan_model(1, 0);
        scan_model(2, 0);

        conv(1, val1[1]);
        scan_model(1, 0);

        for (int i = 0; i < 10; i++) begin
            d = tab[i].d;
            conv(d, tab[i].v);
            nd = (d == 1) ? 3 : 2;
            check($sformatf("tab%0d_ovf", i),
                  (d == 1) ? io1.ovf : io2.ovf, tab[i].o);
            for (int k = 0; k < nd; k++) begin
                scan1(d, p, s);
                t = tab[i].segs >> (8 * p);
                check($sformatf("tab%0d_seg p=%0d", i, p), s, t[7:0]);
            end
        end

        conv(1, val1[0]);
        check("wrap_ch", io1.ch_idx, 0);

        // two extra ticks while converting collapse into one rerun
        c0 = ch1;
        io1.rotate_tick = 1'b1;
        step();
        io1.rotate_tick = 1'b0;
        check("pend_first_ch", io1.ch_idx, (c0 + 1) % 8);
        step();
        step();
        io1.rotate_tick = 1'b1;
        step();
        step();
        io1.rotate_tick = 1'b0;
        io1.hold = 1'b1;
        wait_done(1, lat);
        check("pend_busy_fell", io1.busy, 0);
        step();
        check("pend_restart", io1.busy, 1);
        check("pend_ch", io1.ch_idx, (c0 + 2) % 8);
        wait_done(1, lat);
        check("pend_latency", lat, 10);
        repeat (4) step();
        check("pend_no_third", io1.busy, 0);
        check("pend_ch_final", io1.ch_idx, (c0 + 2) % 8);
        ch1 = (c0 + 2) % 8;

        io1.rotate_tick = 1'b1;
        step();
        io1.rotate_tick = 1'b0;
        check("hold_ch", io1.ch_idx, ch1);
        check("hold_busy", io1.busy, 0);
        repeat (2) step();
        check("hold_busy_late", io1.busy, 0);
        scan_model(1, 1);
        io1.hold = 1'b0;

        // reset on the 4th SHIFT edge discards the partial conversion
        io1.rotate_tick = 1'b1;
        step();
        io1.rotate_tick = 1'b0;
        repeat (5) step();
        rstn = 1'b0;
        #1;
        check("mid_digit", io1.digit, 1);
        check("mid_seg", io1.seg_data, 0);
        check("mid_busy", io1.busy, 1);
        check("mid_ch", io1.ch_idx, 0);
        check("mid_ovf", io1.ovf, 0);
        check("mid_busy2", io2.busy, 1);
        check("mid_digit2", io2.digit, 1);
        io1.vals[7:0] = 8'd37;
        val1[0] = 37;
        ch1 = 0; pos1 = 0; ch2 = 0; pos2 = 0;
        step();
        rstn = 1'b1;
        step();
        io1.vals[7:0] = 8'd99;
        wait_done(1, lat);
        check("mid_latency", lat + 1, 10);
        scan_model(1, 0);
        scan_model(2, 0);
        val1[0] = 99;

        for (int i = 0; i < 16; i++) begin
            d  = (i % 2) + 1;
            v  = $urandom_range(0, 255);
            hd = 1'($urandom_range(0, 1));
            conv(d, v);
            scan_model(d, hd);
            io1.hold = 1'b0;
            io2.hold = 1'b0;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
